// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a one-entry response buffer.
// Define ALU_ARB_FIXED_PRIO_EN to use fixed priority (lowest index wins) in place of round-robin.

module alu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [2:0]            op,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  carry_out,
   output logic                  overflow,
   output logic                  zero
);
   logic [DATA_WIDTH:0] sum;
   logic [DATA_WIDTH:0] diff;
   logic                sub_ovf;

   assign sum     = {1'b0, a} + {1'b0, b};
   assign diff    = {1'b0, a} + {1'b0, ~b} + (DATA_WIDTH+1)'(1);
   assign sub_ovf = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                    (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

   always_comb begin
      result    = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      unique case (op)
         3'b000: result = a & b;
         3'b001: result = a | b;
         3'b010: begin
            result    = sum[DATA_WIDTH-1:0];
            carry_out = sum[DATA_WIDTH];
            overflow  = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                        (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         3'b110: begin
            result    = diff[DATA_WIDTH-1:0];
            carry_out = diff[DATA_WIDTH];
            overflow  = sub_ovf;
         end
         3'b111: result = {{(DATA_WIDTH-1){1'b0}}, diff[DATA_WIDTH-1] ^ sub_ovf};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);
endmodule

// state | meaning
// EMPTY | no response held; any grant may proceed
// FULL  | response buffer valid; new accept only alongside a drain
module alu_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ID_W       = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
   input  logic [NUM_REQ*3-1:0]            req_op,
   output logic                            resp_valid,
   input  logic                            resp_ready,
   output logic [ID_W-1:0]                 resp_id,
   output logic [DATA_WIDTH-1:0]           resp_result,
   output logic [2:0]                      resp_flags,
   output logic                            resp_err
);
   typedef enum logic {EMPTY, FULL} state_t;

   state_t                state, state_nxt;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       g;
   logic [ID_W-1:0]       sel;
   logic                  found;
   logic                  can_acc;
   logic                  accept;
   logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [2:0]            alu_op;
   logic                  alu_carry, alu_ovf, alu_zero;
   logic                  op_illegal;

   assign can_acc = !resp_valid || resp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant = '0;
      g     = '0;
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel = ID_W'(i);
         if (!found && req_valid[sel]) begin
            found      = 1'b1;
            g          = sel;
            grant[sel] = can_acc && rst_n;
         end
      end
   end
`else
   logic [ID_W-1:0] last;

   // Search starts just after the most recent winner so every requester gets a turn.
   always_comb begin
      grant = '0;
      g     = '0;
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sel = ID_W'((int'(last) + k) % NUM_REQ);
         if (!found && req_valid[sel]) begin
            found      = 1'b1;
            g          = sel;
            grant[sel] = can_acc && rst_n;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= ID_W'(NUM_REQ - 1);
      end else if (accept) begin
         last <= g;
      end
   end
`endif

   assign req_ready = grant;
   assign accept    = |grant;

   assign alu_a  = req_a[g*DATA_WIDTH +: DATA_WIDTH];
   assign alu_b  = req_b[g*DATA_WIDTH +: DATA_WIDTH];
   assign alu_op = req_op[g*3 +: 3];
   assign op_illegal = (alu_op == 3'b011) || (alu_op == 3'b100) || (alu_op == 3'b101);

   alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .a         (alu_a),
      .b         (alu_b),
      .op        (alu_op),
      .result    (alu_result),
      .carry_out (alu_carry),
      .overflow  (alu_ovf),
      .zero      (alu_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (accept) state_nxt = FULL;
         FULL:  if (resp_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   assign resp_valid = (state == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_id     <= '0;
         resp_result <= '0;
         resp_flags  <= '0;
         resp_err    <= 1'b0;
      end else if (accept) begin
         resp_id     <= g;
         resp_result <= alu_result;
         resp_flags  <= {alu_ovf, alu_carry, alu_zero};
         resp_err    <= op_illegal;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, grant order, backpressure, illegal ops and ALU vectors.
`timescale 1ns/1ps

module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a, req_b;
   logic [5:0]  req_op;
   logic        resp_valid;
   logic        resp_ready;
   logic [0:0]  resp_id;
   logic [31:0] resp_result;
   logic [2:0]  resp_flags;
   logic        resp_err;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NUM_REQ(2), .ID_W(1), .DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_op      (req_op),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_flags  (resp_flags),
      .resp_err    (resp_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive requester 0 alone, then check the response one cycle later.
   task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r,
                          input logic [2:0] exp_f, input bit chk_f, input logic exp_e);
      req_valid   = 2'b01;
      req_a[31:0] = a;
      req_b[31:0] = b;
      req_op[2:0] = op;
      @(negedge clk);
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_id"}, 32'(resp_id), 32'd0);
      chk({tag, "_result"}, resp_result, exp_r);
      if (chk_f) chk({tag, "_flags"}, 32'(resp_flags), 32'(exp_f));
      chk({tag, "_err"}, 32'(resp_err), 32'(exp_e));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 2'b11;
      resp_ready = 1'b1;
      req_a      = {32'd10, 32'h7FFF_FFFF};
      req_b      = {32'd3,  32'd1};
      req_op     = {3'b110, 3'b010};

      // reset and first grant
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("first_ready", 32'(req_ready), 32'b01);
      chk("first_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("add_result", resp_result, 32'h8000_0000);
      chk("add_flags", 32'(resp_flags), 32'b100);
      chk("add_err", 32'(resp_err), 32'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("second_ready", 32'(req_ready), 32'b01);
`else
      chk("second_ready", 32'(req_ready), 32'b10);
`endif

      // grant rotation with both requesters valid
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rot_valid%0d", i), 32'(resp_valid), 32'd1);
`ifdef ALU_ARB_FIXED_PRIO_EN
         chk($sformatf("rot_id%0d", i), 32'(resp_id), 32'd0);
`else
         chk($sformatf("rot_id%0d", i), 32'(resp_id), 32'(i % 2));
`endif
         @(negedge clk);
      end

      // backpressure: buffer holds requester 0's add
      resp_ready   = 1'b0;
      req_valid    = 2'b10;
      req_a[63:32] = 32'd5;
      req_b[63:32] = 32'd3;
      req_op[5:3]  = 3'b100;
      #1;
      chk("bp_ready0", 32'(req_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("bp_ready%0d", i + 1), 32'(req_ready), 32'd0);
         chk($sformatf("bp_valid%0d", i), 32'(resp_valid), 32'd1);
         chk($sformatf("bp_id%0d", i), 32'(resp_id), 32'd0);
         chk($sformatf("bp_result%0d", i), resp_result, 32'h8000_0000);
         chk($sformatf("bp_flags%0d", i), 32'(resp_flags), 32'b100);
      end
      resp_ready = 1'b1;
      #1;
      chk("drain_acc_ready", 32'(req_ready), 32'b10);

      // illegal op from requester 1 after same-cycle drain+accept
      @(negedge clk);
      chk("ill_valid", 32'(resp_valid), 32'd1);
      chk("ill_id", 32'(resp_id), 32'd1);
      chk("ill_result", resp_result, 32'd0);
      chk("ill_flags", 32'(resp_flags), 32'b001);
      chk("ill_err", 32'(resp_err), 32'd1);

      // slt from requester 1, then asynchronous reset with the buffer full
      req_a[63:32] = 32'd1;
      req_b[63:32] = 32'd2;
      req_op[5:3]  = 3'b111;
      @(negedge clk);
      chk("slt_id", 32'(resp_id), 32'd1);
      chk("slt_result", resp_result, 32'd1);
      chk("slt_err", 32'(resp_err), 32'd0);
      req_valid = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(resp_valid), 32'd0);
      chk("arst_result", resp_result, 32'd0);
      chk("arst_id", 32'(resp_id), 32'd0);
      chk("arst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", 32'(req_ready), 32'd0);

      // ALU vectors through requester 0
      run_vec("and",    3'b000, 32'h0000_0F0F, 32'h0000_00FF, 32'h0000_000F, 3'b000, 1'b1, 1'b0);
      run_vec("or0",    3'b001, 32'h0,         32'h0,         32'h0,         3'b001, 1'b1, 1'b0);
      run_vec("addc",   3'b010, 32'hFFFF_FFFF, 32'h1,         32'h0,         3'b011, 1'b1, 1'b0);
      run_vec("addov",  3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0,         3'b111, 1'b1, 1'b0);
      run_vec("sub",    3'b110, 32'd10,        32'd3,         32'd7,         3'b000, 1'b0, 1'b0);
      run_vec("sltneg", 3'b111, 32'hFFFF_FFFF, 32'h1,         32'h1,         3'b000, 1'b0, 1'b0);
      run_vec("sltpos", 3'b111, 32'd5,         32'd3,         32'h0,         3'b000, 1'b0, 1'b0);
      run_vec("ill101", 3'b101, 32'd9,         32'd9,         32'h0,         3'b001, 1'b1, 1'b1);

      req_valid = 2'b00;
      @(negedge clk);
      chk("drain_valid", 32'(resp_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
